// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_pkg
// Brief    : Shared block geometry and state encoding for the cache fill FSM.
// Revision : 1.0 - initial release
// ============================================================================
package cache_fill_fsm_pkg;

    localparam int unsigned C_BLOCK_WORDS = 8;
    localparam int unsigned C_OFFSET_W    = 3;
    localparam int unsigned C_CNT_W       = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Brief    : Small up-counter with synchronous clear and increment enable.
// Revision : 1.0 - initial release
// ============================================================================
module fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WIDTH = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Brief    : Block fill sequencer: issues word reads, writes returns into data
//            array, then writes the tag on the final word.
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = C_BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [15:0]           miss_address,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [15:0]           mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data_in,
    output logic                  write_data_array,
    output logic [C_OFFSET_W-1:0] word_offset,
    output logic [15:0]           fill_data,
    output logic                  write_tag_array
);

    localparam logic [C_CNT_W-1:0] C_REQ_END   = C_CNT_W'(BLOCK_WORDS);
    localparam logic [C_CNT_W-1:0] C_LAST_WORD = C_CNT_W'(BLOCK_WORDS - 1);

    fill_state_t           r_state;
    logic [15:0]           r_base;
    logic [C_CNT_W-1:0]    w_req_cnt;
    logic [C_CNT_W-1:0]    w_rcv_cnt;
    logic                  w_start;
    logic                  w_in_fill;
    logic                  w_req_active;
    logic [C_OFFSET_W-1:0] w_req_idx;
    logic                  w_unused_ok;

    assign w_start      = (r_state == ST_IDLE) && miss_detected;
    assign w_in_fill    = (r_state == ST_FILL);
    assign w_req_active = w_in_fill && (w_req_cnt < C_REQ_END);

    // After the last request the address parks on the final word of the block.
    assign w_req_idx = w_req_active ? w_req_cnt[C_OFFSET_W-1:0]
                                    : C_LAST_WORD[C_OFFSET_W-1:0];

    assign fsm_busy         = w_in_fill;
    assign mem_enable       = w_req_active;
    assign mem_addr         = w_in_fill ? (r_base + {{(16-C_OFFSET_W-1){1'b0}}, w_req_idx, 1'b0})
                                        : 16'h0000;
    assign write_data_array = w_in_fill && mem_data_valid;
    assign word_offset      = w_in_fill ? w_rcv_cnt[C_OFFSET_W-1:0] : '0;
    assign fill_data        = mem_data_in;
    assign write_tag_array  = write_data_array && (w_rcv_cnt == C_LAST_WORD);

    // Byte offset within the block is discarded when the base is latched.
    assign w_unused_ok = ^miss_address[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        r_base  <= {miss_address[15:4], 4'h0};
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (write_tag_array) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fill_counter #(.WIDTH(C_CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .inc   (w_req_active),
        .count (w_req_cnt)
    );

    fill_counter #(.WIDTH(C_CNT_W)) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .inc   (write_data_array),
        .count (w_rcv_cnt)
    );

endmodule
`default_nettype wire
